// File: rtl/sw_event_fsm.sv
// Switch gesture classifier: short, long and double press from a debounced level.
// Emits one-cycle event pulses and drives the board LED from them.
module sw_event_fsm #(
    parameter int unsigned LONG_CYCLES       = 50_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
    parameter int          CNT_W             = 26
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic sw_db_i,
    output logic short_press_o,
    output logic long_press_o,
    output logic double_press_o,
    output logic led_o
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        GAP,
        SECOND
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             sw_q;
    logic             rise, fall;
    logic             short_nx, long_nx, double_nx, led_nx;

    assign rise    = sw_db_i & ~sw_q;
    assign fall    = ~sw_db_i & sw_q;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        led_nx    = led_o;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    cnt_nx   = CNT_ONE;
                end
            end
            PRESSED: begin
                if (sw_db_i) begin
                    if (cnt >= LONG_LAST) begin
                        state_nx = LONG_HELD;
                        cnt_nx   = '0;
                        long_nx  = 1'b1;
                        led_nx   = 1'b0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = GAP;
                    cnt_nx   = CNT_ONE;
                end
            end
            // sw_q is always 1 while here, so fall equals a low sample
            LONG_HELD: begin
                if (fall) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            GAP: begin
                if (!sw_db_i) begin
                    if (cnt >= GAP_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        short_nx = 1'b1;
                        led_nx   = ~led_o;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = SECOND;
                    cnt_nx   = '0;
                end
            end
            SECOND: begin
                if (fall) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    double_nx = 1'b1;
                    led_nx    = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // sw_q resets high so a switch held through reset needs a fresh press
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            sw_q           <= 1'b1;
            short_press_o  <= 1'b0;
            long_press_o   <= 1'b0;
            double_press_o <= 1'b0;
            led_o          <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            sw_q           <= sw_db_i;
            short_press_o  <= short_nx;
            long_press_o   <= long_nx;
            double_press_o <= double_nx;
            led_o          <= led_nx;
        end
    end

endmodule

// File: tb/tb_sw_event_fsm.sv
// Directed bench for sw_event_fsm with LONG_CYCLES=20, DOUBLE_GAP_CYCLES=10.
// Outputs are sampled 1 ns after each rising edge.
module tb_sw_event_fsm;

    logic clk_50 = 1'b0;
    logic reset_n = 1'b0;
    logic sw_db_i = 1'b0;
    logic short_press_o, long_press_o, double_press_o, led_o;

    int n_cmp = 0;
    int n_err = 0;
    int sc = 0, lc = 0, dc = 0, multi = 0;

    sw_event_fsm #(
        .LONG_CYCLES(20),
        .DOUBLE_GAP_CYCLES(10),
        .CNT_W(8)
    ) dut (
        .clk_50(clk_50),
        .reset_n(reset_n),
        .sw_db_i(sw_db_i),
        .short_press_o(short_press_o),
        .long_press_o(long_press_o),
        .double_press_o(double_press_o),
        .led_o(led_o)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v);
        sw_db_i = v;
        @(posedge clk_50);
        #1;
        sc += int'(short_press_o);
        lc += int'(long_press_o);
        dc += int'(double_press_o);
        if (int'(short_press_o) + int'(long_press_o) + int'(double_press_o) > 1)
            multi++;
    endtask

    task automatic ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic clr();
        sc = 0;
        lc = 0;
        dc = 0;
    endtask

    task automatic short_gesture(input string tag, input int led_exp);
        ticks(1'b1, 5);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            chk({tag, "_short"}, int'(short_press_o), int'(i == 10));
        end
        chk({tag, "_led"}, int'(led_o), led_exp);
        tick(1'b0);
        chk({tag, "_width"}, int'(short_press_o), 0);
    endtask

    initial begin
        // 1: reset
        #5;
        chk("rst_short", int'(short_press_o), 0);
        chk("rst_long", int'(long_press_o), 0);
        chk("rst_double", int'(double_press_o), 0);
        chk("rst_led", int'(led_o), 0);
        #295 reset_n = 1'b1;
        @(posedge clk_50);
        #1;
        clr();
        ticks(1'b0, 50);
        chk("idle_pulses", sc + lc + dc, 0);

        // 2: short press toggles LED twice
        clr();
        short_gesture("s1", 1);
        short_gesture("s2", 0);
        chk("s_count", sc, 2);
        chk("s_others", lc + dc, 0);

        // 4: double press
        clr();
        ticks(1'b1, 3);
        ticks(1'b0, 4);
        ticks(1'b1, 3);
        chk("d_early", dc, 0);
        tick(1'b0);
        chk("d_pulse", int'(double_press_o), 1);
        chk("d_led", int'(led_o), 1);
        ticks(1'b0, 15);
        chk("d_count", dc, 1);
        chk("d_noshort", sc + lc, 0);

        // 3: long press clears LED
        clr();
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1);
            chk("l_pulse", int'(long_press_o), int'(i == 20));
            if (i == 20) chk("l_led", int'(led_o), 0);
        end
        ticks(1'b0, 15);
        chk("l_count", lc, 1);
        chk("l_others", sc + dc, 0);

        // 5: gap expiry then new press is a fresh PRESSED
        clr();
        ticks(1'b1, 3);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            chk("g_short", int'(short_press_o), int'(i == 10));
        end
        chk("g_led", int'(led_o), 1);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1);
            chk("g_long", int'(long_press_o), int'(i == 20));
        end
        chk("g_led2", int'(led_o), 0);
        ticks(1'b0, 15);
        chk("g_nodouble", dc, 0);
        chk("g_short_cnt", sc, 1);

        // 6a: switch held through reset release
        reset_n = 1'b0;
        sw_db_i = 1'b1;
        #50 reset_n = 1'b1;
        clr();
        ticks(1'b1, 40);
        ticks(1'b0, 15);
        chk("h_pulses", sc + lc + dc, 0);

        // 6b: reset kills a pulse in flight
        ticks(1'b1, 3);
        ticks(1'b0, 10);
        chk("f_short", int'(short_press_o), 1);
        chk("f_led", int'(led_o), 1);
        reset_n = 1'b0;
        #2;
        chk("f_rst_short", int'(short_press_o), 0);
        chk("f_rst_led", int'(led_o), 0);
        #20 reset_n = 1'b1;
        @(posedge clk_50);
        #1;

        // 6c: reset mid-GAP
        clr();
        ticks(1'b1, 3);
        ticks(1'b0, 5);
        reset_n = 1'b0;
        #2;
        chk("m_short", int'(short_press_o), 0);
        chk("m_long", int'(long_press_o), 0);
        chk("m_double", int'(double_press_o), 0);
        chk("m_led", int'(led_o), 0);
        #30 reset_n = 1'b1;
        ticks(1'b0, 20);
        chk("m_pulses", sc + lc + dc, 0);
        chk("onehot", multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_event_fsm.md
Name: sw_event_fsm

Overview:
- Sits directly downstream of the switch debouncer in my_project.
- Consumes the debounced, clk_50-synchronous switch level and classifies each gesture as short press, long press or double press.
- Emits a one-cycle pulse per classified gesture and drives the board LED from those events.
- All timing is in clock cycles so the bench can override the parameters with small values.

Parameters:
LONG_CYCLES, 50_000_000, consecutive high samples that make a press "long" (1 s at 50 MHz); legal range 2..2^CNT_W-1
DOUBLE_GAP_CYCLES, 12_500_000, consecutive low samples after a short release that close the double-press window (250 ms); legal range 2..2^CNT_W-1
CNT_W, 26, cycle counter width; must hold max(LONG_CYCLES, DOUBLE_GAP_CYCLES)

Ports:
clk_50  input  1  system clock, 50 MHz; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
sw_db_i  input  1  debounced switch level, 1 = pressed, already synchronous to clk_50
short_press_o  output  1  one-cycle pulse: short press with no second press
long_press_o  output  1  one-cycle pulse: press held LONG_CYCLES samples
double_press_o  output  1  one-cycle pulse: second press completed inside gap window
led_o  output  1  LED drive; toggles on short, cleared on long, set on double

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, counter = 0.
  - short_press_o, long_press_o, double_press_o and led_o = 0.
  - The previous-sample register sw_q resets to 1, so a switch held through reset release is ignored until it is released and pressed again.
- Edge detection:
  - rise = sw_db_i & ~sw_q.
  - fall = ~sw_db_i & sw_q.
  - sw_q <= sw_db_i every cycle.
- States: IDLE, PRESSED, LONG_HELD, GAP, SECOND.
- IDLE:
  - rise -> PRESSED, counter = 1.
  - fall is ignored.
- PRESSED:
  - Each high sample increments the counter.
  - On the LONG_CYCLES-th consecutive high sample -> LONG_HELD; long_press_o = 1 for the next cycle only; led_o <= 0 on the same edge.
  - A low sample before that count -> GAP, counter = 1. That low sample is the first gap sample.
- LONG_HELD:
  - Waits for a low sample, then -> IDLE.
  - Never emits short or double.
- GAP:
  - Each low sample increments the counter.
  - On the DOUBLE_GAP_CYCLES-th consecutive low sample -> IDLE; short_press_o = 1 for the next cycle; led_o <= ~led_o.
  - A high sample before that count -> SECOND.
- SECOND:
  - On the first low sample -> IDLE; double_press_o = 1 for the next cycle; led_o <= 1.
  - The second press has no long-press timeout and may be any length.
- Output timing:
  - All outputs are registered.
  - Each pulse and its led_o update appear together on the same clock edge.
  - At most one of the three pulse outputs is high in any cycle.
  - A pulse is never longer than one cycle.
- Boundaries:
  - The counter saturates and never wraps. It is always reset on a state change.
  - A release exactly on the LONG_CYCLES-th sample cannot occur, because that sample is high by definition.
  - A high sample exactly on the DOUBLE_GAP_CYCLES-th gap sample cannot occur, because that sample is low by definition, so short wins.
  - reset_n asserted in any state clears all outputs immediately, including a pulse in flight. No event is emitted after release from a gesture begun before reset.
  - Input glitches shorter than one cycle are not handled; the debouncer guarantees a clean input.

Test Plan:
All scenarios run with LONG_CYCLES=20 and DOUBLE_GAP_CYCLES=10.
1. reset_n=0 with sw_db_i=0, release after 300 ns -> all four outputs 0; no pulses for 50 idle cycles.
2. Hold sw_db_i=1 for 5 cycles, then 0 -> short_press_o high exactly 1 cycle, 10 cycles after the first low sample; led_o 0->1. Repeat the gesture -> led_o 1->0.
3. Hold sw_db_i=1 for 30 cycles -> long_press_o 1-cycle pulse after the 20th high sample; led_o=0; no short or double pulse after release.
4. High 3 cycles, low 4, high 3, low -> double_press_o pulse 1 cycle after the second release sample; led_o=1; short_press_o never asserts.
5. High 3, low exactly 10 cycles, then high -> short_press_o fires at the 10th low sample; the new high starts a fresh PRESSED, not SECOND.
6. sw_db_i=1 through reset release, release after 40 cycles -> no pulses. Assert reset_n=0 mid-GAP (after 5 low samples) -> outputs 0 at once and no short pulse after reset release.
